// File: rtl/logic_pipe_unit.sv
// logic_pipe_unit
//
// Purpose:
//   Bitwise logic unit behind a STAGES-deep valid/ready pipeline. Every beat
//   gets its result at the input and carries it down the stages together
//   with a zero flag (and, optionally, a parity bit). The chain is elastic:
//   each stage has its own valid bit. A stage takes a new beat when it is
//   empty or when its current beat moves on in the same cycle. The unit can
//   therefore accept one beat per cycle while out_ready stays high.
//
// Handshake:
//   A beat moves on a rising edge when its valid and the receiver's ready
//   are both high.
//   - Input side: in_valid / in_ready.
//   - Output side: out_valid / out_ready.
//   A producer that has raised valid keeps its data stable until the
//   handshake completes. in_ready depends combinationally on out_ready
//   through the stage chain.
//
// Parameters:
//   WIDTH  - operand/result width in bits (1..64)
//   STAGES - number of register stages (1..4)
//
// Ports:
//   clk, rst           - clock; asynchronous active-high reset
//   in_valid, in_ready - input beat handshake
//   a, b, op           - operands and operation select, sampled with the beat
//                        op: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR,
//                            101 XNOR, 110 NOT a, 111 pass a
//   out_valid, out_ready - output beat handshake
//   y, zero            - result and its all-zeros flag (both registered)
//   parity             - XOR reduction of y; present only when
//                        LOGIC_PIPE_UNIT_PARITY_EN is defined
//   done_cnt           - completed output handshakes, saturating at 0xFFFF
//
// Configuration macro: LOGIC_PIPE_UNIT_PARITY_EN

module logic_pipe_unit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
    output logic             parity,
`endif
    output logic [15:0]      done_cnt
);

    // Result of the beat currently offered at the input.
    logic [WIDTH-1:0] res;
    logic             res_zero;

    always_comb begin
        res = '0;
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = ~(a & b);
            3'b011:  res = ~(a | b);
            3'b100:  res = a ^ b;
            3'b101:  res = ~(a ^ b);
            3'b110:  res = ~a;
            default: res = a;
        endcase
        res_zero = (res == '0);
    end

    // Stage state. Index 0 is the stage nearest the input; index STAGES-1
    // drives the outputs.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] zero_q, zero_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
    logic [STAGES-1:0] par_q, par_d;
`endif

    // rdy[k] is high when stage k can take a beat this cycle.
    // rdy[STAGES] is the downstream ready.
    logic [STAGES:0] rdy;

    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        // Walk from the output back to the input, so that a free slot
        // anywhere downstream reaches in_ready in the same cycle.
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !valid_q[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        data_d  = data_q;
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
        par_d   = par_q;
`endif
        // First stage takes from the input port.
        if (rdy[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = res;
                zero_d[0] = res_zero;
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
                par_d[0]  = ^res;
`endif
            end
        end
        // Later stages take from their predecessor. When a bubble moves in,
        // the payload is left as it is so that y does not toggle needlessly.
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    zero_d[k] = zero_q[k-1];
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
                    par_d[k]  = par_q[k-1];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= '0;
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
            par_q   <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
            par_q   <= par_d;
`endif
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign y         = data_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
    assign parity    = par_q[STAGES-1];
`endif

    // Completed output handshakes, held at the top value once reached.
    logic [15:0] done_cnt_q, done_cnt_d;

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (out_valid && out_ready && (done_cnt_q != 16'hFFFF)) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Directed testbench for logic_pipe_unit (WIDTH=8, STAGES=2).
//
// Timing of the bench:
// - Inputs change 1 ns after a rising edge.
// - Combinational outputs are sampled 1 ns after that.
// - Registered outputs are sampled 1 ns after the edge.

module tb_logic_pipe_unit;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [15:0]      done_cnt;
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
    logic             parity;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_done;

    logic_pipe_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
        .parity    (parity),
`endif
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic [2:0] ov);
        in_valid = v;
        a        = av;
        b        = bv;
        op       = ov;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        #2;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (y !== 8'h00) begin fails++; $display("FAIL reset_y: got %h expected 00", y); end
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b expected 0", zero); end
        tests++; if (done_cnt !== 16'h0000) begin fails++; $display("FAIL reset_done_cnt: got %h expected 0000", done_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        // A beat offered while reset is held must not be taken.
        drive(1'b1, 8'hFF, 8'hFF, 3'd7);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_accept: got %b expected 0", out_valid); end
        exp_done = 16'h0000;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b1, 8'hF0, 8'hCC, 3'b010);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_latency_early: got %b expected 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        tests++; if (y !== 8'h3F) begin fails++; $display("FAIL basic_y: got %h expected 3f", y); end
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL basic_zero: got %b expected 0", zero); end
        tests++; if (done_cnt !== exp_done) begin fails++; $display("FAIL basic_done_pre: got %h expected %h", done_cnt, exp_done); end
        tick();
        exp_done = exp_done + 16'd1;
        tests++; if (done_cnt !== exp_done) begin fails++; $display("FAIL basic_done_cnt: got %h expected %h", done_cnt, exp_done); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_y [8];
        exp_y[0] = 8'h0A; exp_y[1] = 8'hAF; exp_y[2] = 8'hF5; exp_y[3] = 8'h50;
        exp_y[4] = 8'hA5; exp_y[5] = 8'h5A; exp_y[6] = 8'h55; exp_y[7] = 8'hAA;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 8'hAA, 8'h0F, 3'(i));
            else       drive(1'b0, 8'h00, 8'h00, 3'd0);
            #1;
            if (i < 8) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            end
            tick();
            if (i >= 1 && i <= 8) begin
                tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_out_valid[%0d]: got %b expected 1", i, out_valid); end
                tests++; if (y !== exp_y[i-1]) begin fails++; $display("FAIL b2b_y[%0d]: got %h expected %h", i, y, exp_y[i-1]); end
            end else begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_bubble[%0d]: got %b expected 0", i, out_valid); end
            end
        end
        exp_done = exp_done + 16'd8;
        tests++; if (done_cnt !== exp_done) begin fails++; $display("FAIL b2b_done_cnt: got %h expected %h", done_cnt, exp_done); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 8'h12, 8'h34, 3'b001);   // expect 36
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_fill0: got %b expected 1", in_ready); end
        tick();
        drive(1'b1, 8'hFF, 8'h0F, 3'b000);   // expect 0F
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_fill1: got %b expected 1", in_ready); end
        tick();
        // Pipeline full. Wiggle the operands while in_ready is low; none of
        // this may be taken.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_out_valid[%0d]: got %b expected 1", i, out_valid); end
            tests++; if (y !== 8'h36) begin fails++; $display("FAIL stall_y[%0d]: got %h expected 36", i, y); end
            tick();
        end
        // Release with a new beat on offer: shift and accept in one edge.
        drive(1'b1, 8'h55, 8'h00, 3'b110);   // expect AA
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
        tests++; if (y !== 8'h36) begin fails++; $display("FAIL stall_out0: got %h expected 36", y); end
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tests++; if (y !== 8'h0F || out_valid !== 1'b1) begin fails++; $display("FAIL stall_out1: got %h/%b expected 0f/1", y, out_valid); end
        tick();
        tests++; if (y !== 8'hAA || out_valid !== 1'b1) begin fails++; $display("FAIL stall_out2: got %h/%b expected aa/1", y, out_valid); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drained: got %b expected 0", out_valid); end
        exp_done = exp_done + 16'd3;
        tests++; if (done_cnt !== exp_done) begin fails++; $display("FAIL stall_done_cnt: got %h expected %h", done_cnt, exp_done); end
    endtask

    task automatic test_zero_parity();
        out_ready = 1'b1;
        drive(1'b1, 8'h3C, 8'h3C, 3'b100);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        tests++; if (y !== 8'h00 || out_valid !== 1'b1) begin fails++; $display("FAIL zero_y: got %h/%b expected 00/1", y, out_valid); end
        tests++; if (zero !== 1'b1) begin fails++; $display("FAIL zero_flag: got %b expected 1", zero); end
        tick();
        drive(1'b1, 8'h07, 8'hFF, 3'b111);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tick();
        tests++; if (y !== 8'h07) begin fails++; $display("FAIL pass_y: got %h expected 07", y); end
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL pass_zero: got %b expected 0", zero); end
`ifdef LOGIC_PIPE_UNIT_PARITY_EN
        tests++; if (parity !== 1'b1) begin fails++; $display("FAIL parity: got %b expected 1", parity); end
`endif
        tick();
        exp_done = exp_done + 16'd2;
        tests++; if (done_cnt !== exp_done) begin fails++; $display("FAIL zero_done_cnt: got %h expected %h", done_cnt, exp_done); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1'b1, 8'hF0, 8'h0F, 3'b001);
        tick();
        drive(1'b1, 8'h01, 8'h01, 3'b000);
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_in_flight: got %b expected 1", out_valid); end
        #2;
        rst = 1'b1;
        drive(1'b1, 8'hAA, 8'h00, 3'b111);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        tests++; if (y !== 8'h00) begin fails++; $display("FAIL rmid_y: got %h expected 00", y); end
        tests++; if (done_cnt !== 16'h0000) begin fails++; $display("FAIL rmid_done_cnt: got %h expected 0000", done_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        tick();
        tick();
        // Release between edges with a beat waiting; the next edge takes it.
        rst = 1'b0;
        drive(1'b1, 8'h3C, 8'h0F, 3'b000);   // expect 0C
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_first_ready: got %b expected 1", in_ready); end
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_stale: got %b expected 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1 || y !== 8'h0C) begin fails++; $display("FAIL rmid_first_beat: got %b/%h expected 1/0c", out_valid, y); end
        tick();
        exp_done = 16'h0001;
        tests++; if (done_cnt !== exp_done) begin fails++; $display("FAIL rmid_done_cnt_after: got %h expected %h", done_cnt, exp_done); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_cnt;
        out_ready = 1'b1;
        force dut.done_cnt_q = 16'hFFFE;
        #1;
        release dut.done_cnt_q;
        tests++; if (done_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_preload: got %h expected fffe", done_cnt); end
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1'b1, 8'(i + 1), 8'h00, 3'b111);
            else       drive(1'b0, 8'h00, 8'h00, 3'd0);
            tick();
            // Handshakes complete on edges 2, 3 and 4 of this loop.
            exp_cnt = (i >= 2) ? 16'hFFFF : 16'hFFFE;
            tests++; if (done_cnt !== exp_cnt) begin fails++; $display("FAIL sat_done_cnt[%0d]: got %h expected %h", i, done_cnt, exp_cnt); end
        end
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_zero_parity();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/logic_pipe_unit.md
LOGIC_PIPE_UNIT -- requirements
Module: logic_pipe_unit

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits; legal 1..64.
REQ-002 Parameter STAGES, default 2, meaning pipeline depth in register stages; legal 1..4.
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  upstream beat present.
REQ-006 Port in_ready  output  1  unit accepts beat this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port op  input  3  operation select, sampled with the beat.
REQ-010 Port out_valid  output  1  result beat present.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port y  output  WIDTH  bitwise result.
REQ-013 Port zero  output  1  high when y is all zeros.
REQ-014 Port done_cnt  output  16  count of completed output handshakes.

Function
REQ-015 op encoding SHALL be: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 pass a; b is ignored for 110/111.
REQ-016 Result SHALL be computed bitwise over all WIDTH bits with no carries or cross-bit dependency.
REQ-017 Input beat SHALL be accepted when in_valid && in_ready on a rising edge.
REQ-018 Pipeline SHALL hold STAGES register stages, each with its own valid bit; data and op travel with their beat.
REQ-019 Stage k SHALL load from stage k-1 when stage k is empty or stage k itself advances in the same cycle.
REQ-020 in_ready SHALL equal !stage1_valid || stage1_advances, i.e. combinationally derived from out_ready through the chain, so the unit sustains one beat per cycle.
REQ-021 Latency from accepted input to out_valid SHALL be exactly STAGES cycles when out_ready is held high.
REQ-022 While out_valid && !out_ready, y, zero and out_valid SHALL remain stable; no beat SHALL be dropped or duplicated.
REQ-023 Full pipeline (all stages valid) with out_ready low SHALL deassert in_ready.
REQ-024 Simultaneous output handshake and input accept on a full pipeline SHALL shift all stages by one and accept the new beat.
REQ-025 zero SHALL be registered with y in the final stage, not derived after it.
REQ-026 done_cnt SHALL increment by 1 on each out_valid && out_ready edge and saturate at 0xFFFF.
REQ-027 Changes on a, b, op while in_ready is low SHALL have no effect.

Reset
REQ-028 On rst high, all stage valid bits, out_valid, y, zero and done_cnt SHALL clear to 0 immediately, independent of clk.
REQ-029 During reset in_ready SHALL be 1 and no beat SHALL be accepted; beats in flight at reset assertion SHALL be discarded.
REQ-030 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro LOGIC_PIPE_UNIT_PARITY_EN SHALL, when defined, add output port parity (1 bit) carrying the XOR reduction of y, registered alongside y, reset to 0 and held under stall.
REQ-032 Without LOGIC_PIPE_UNIT_PARITY_EN the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 WIDTH=8, STAGES=2, out_ready=1: a=0xF0, b=0xCC, op=010 accepted at cycle 0 -> y=0x3F, out_valid=1 at cycle 2, zero=0, done_cnt=1 after handshake.
REQ-034 Back-to-back ops 000..111 with a=0xAA, b=0x0F -> y sequence 0x0A,0xAF,0xF5,0x50,0xA5,0x5A,0x55,0xAA, one per cycle, no bubbles.
REQ-035 Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, y frozen; release -> STAGES results emerge in order, none lost.
REQ-036 a=0x3C, b=0x3C, op=100 -> y=0x00, zero=1; with LOGIC_PIPE_UNIT_PARITY_EN, a=0x07, op=111 -> parity=1.
REQ-037 Assert rst asynchronously mid-stream with two beats in flight -> out_valid, y, done_cnt=0 before next edge; no stale beat appears after release.
REQ-038 Force done_cnt to 0xFFFE then complete 3 handshakes -> done_cnt=0xFFFF and stays.
